bpsk_symbol_ctrl: RTL and testbench
===================================

BPSK_SYMBOL_CTRL -- requirements
Module: bpsk_symbol_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_NUMBER, default 256: carrier samples per symbol (power of two, at least 4).
REQ-002 SHALL have parameter DATA_WIDTH, default 12: bits per input word.
REQ-003 SHALL have parameter PREAMBLE_LEN, default 8: preamble symbols per frame (at least 1).
REQ-004 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port en, input, 1: global advance enable.
REQ-007 SHALL have port s_data, input, DATA_WIDTH: word to transmit, MSB first.
REQ-008 SHALL have port s_valid, input, 1: s_data is valid.
REQ-009 SHALL have port s_ready, output, 1: word accepted when s_valid, s_ready and en are all 1.
REQ-010 SHALL have port sample_idx, output, log2(SAMPLE_NUMBER): carrier LUT address.
REQ-011 SHALL have port sym_bit, output, 1: 1 selects +sine, 0 selects -sine.
REQ-012 SHALL have port sym_valid, output, 1: modulator output is meaningful.
REQ-013 SHALL have port sym_start, output, 1: high while sample_idx==0 and sym_valid==1.
REQ-014 SHALL have port frame_done, output, 1: one-cycle pulse at frame end.
REQ-015 SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, PREAMBLE and DATA.
REQ-017 In IDLE: s_ready=en, sym_valid=0, sym_bit=0, sample_idx=0.
REQ-018 Accept in IDLE: capture s_data into the shift register, clear the sample and symbol counters, and go to PREAMBLE (DATA when the macro is absent).
REQ-019 Outside IDLE with en=1: sample_idx increments every cycle and wraps SAMPLE_NUMBER-1 -> 0; the wrap marks the symbol boundary.
REQ-020 PREAMBLE: sym_bit alternates 1,0,1,... starting at 1, one value per symbol, for PREAMBLE_LEN symbols, then DATA.
REQ-021 DATA: sym_bit = shift register MSB; the register shifts left by one at each symbol boundary; the phase lasts DATA_WIDTH symbols.
REQ-022 s_ready SHALL also be high (gated by en) during the last sample of the last data symbol.
REQ-023 On accept during that last sample: load the new word and stay in DATA, with no preamble and no gap symbol; otherwise go to IDLE.
REQ-024 frame_done pulses on the last sample of the last data symbol, whether or not the next word is back-to-back.
REQ-025 Latency: accept at cycle N -> sym_valid=1, sample_idx=0 and sym_start=1 at cycle N+1.
REQ-026 en=0 freezes state, counters, shift register and all outputs; s_ready=0 and frame_done=0 while en=0.
REQ-027 A change in s_data after accept SHALL NOT affect the current word.

Reset
REQ-028 rst=1 SHALL force IDLE immediately, asynchronously, including mid-symbol or mid-frame; the partial frame is discarded.
REQ-029 Reset values SHALL be: s_ready=0 while rst=1, sample_idx=0, sym_bit=0, sym_valid=0, sym_start=0, frame_done=0, busy=0, and the shift register and counters cleared.
REQ-030 The first accept is possible on the first rising edge after rst falls, provided en=1.

Configuration
REQ-031 Macro BPSK_CTRL_PREAMBLE_EN defined: the PREAMBLE state and its counter SHALL be compiled in, behaving as REQ-018 and REQ-020.
REQ-032 Macro BPSK_CTRL_PREAMBLE_EN undefined: the PREAMBLE logic SHALL be absent, accept goes straight to DATA, and a frame lasts DATA_WIDTH symbols.

Verification (SAMPLE_NUMBER=256, DATA_WIDTH=12, PREAMBLE_LEN=8)
REQ-033 Macro on, word 0xA5C accepted at cycle 0 -> sym_bit sequence 10101010 then 101001011100, 256 cycles per symbol, busy=1 for 5120 cycles, frame_done at cycle 5120, then IDLE.
REQ-034 Macro off, same word -> 12 symbols only, frame_done at cycle 3072, no preamble pattern seen.
REQ-035 Words 0xFFF then 0x000, second held valid -> second accepted on the frame_done cycle, sym_bit goes 1 -> 0 with no preamble, and sym_start stays periodic every 256 cycles.
REQ-036 en=0 for 100 cycles at sample_idx=37 of data bit 3 -> all outputs frozen; after en=1, resume at 38; frame_done delayed exactly 100 cycles.
REQ-037 rst pulse at sample_idx=200 of preamble symbol 5 -> outputs at reset values within the same cycle; a new accept afterwards restarts the preamble at symbol 0.
REQ-038 s_valid=1 with en=0 in IDLE -> no accept, s_ready=0, busy stays 0.

Source files
------------

// File: rtl/bpsk_symbol_ctrl.sv
// bpsk_symbol_ctrl -- symbol sequencer for a LUT-based BPSK modulator.
//
// Takes one DATA_WIDTH-bit word per frame and walks the carrier LUT address
// (sample_idx) through SAMPLE_NUMBER samples per symbol. Each symbol's
// polarity is given on sym_bit. A frame can optionally begin with an
// alternating 1,0,1,... preamble of PREAMBLE_LEN symbols. The frame then
// sends the word MSB first. A new word offered during the last sample of a
// frame is chained into the next frame with no gap and no preamble.
//
// Build option:
//   BPSK_CTRL_PREAMBLE_EN  defined   -> PREAMBLE state and counter present
//                          undefined -> accept goes straight to DATA
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   en              global advance enable (freezes everything when low)
//   s_data/s_valid  word input; s_ready indicates acceptance (with en)
//   sample_idx      carrier LUT address
//   sym_bit         1 = +sine, 0 = -sine
//   sym_valid       modulator output meaningful (not IDLE)
//   sym_start       first sample of a symbol
//   frame_done      one-cycle pulse on the last sample of a frame
//   busy            state is not IDLE
module bpsk_symbol_ctrl #(
  parameter int SAMPLE_NUMBER = 256,
  parameter int DATA_WIDTH    = 12,
  parameter int PREAMBLE_LEN  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [DATA_WIDTH-1:0]            s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic [$clog2(SAMPLE_NUMBER)-1:0] sample_idx,
  output logic                             sym_bit,
  output logic                             sym_valid,
  output logic                             sym_start,
  output logic                             frame_done,
  output logic                             busy
);

  localparam int SW      = $clog2(SAMPLE_NUMBER);
  localparam int CNT_MAX = (DATA_WIDTH > PREAMBLE_LEN) ? DATA_WIDTH : PREAMBLE_LEN;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         sample_q, sample_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;

  logic last_sample;
  logic last_data;
  logic accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sample_q <= '0;
      cnt_q    <= '0;
      shreg_q  <= '0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;

    // SAMPLE_NUMBER is a power of two, so the all-ones index is the symbol end
    // and the +1 below wraps to 0 on its own.
    last_sample = (sample_q == {SW{1'b1}});
    last_data   = (state_q == DATA) && last_sample && (cnt_q == CW'(DATA_WIDTH - 1));

    // rst gating keeps s_ready low for the whole reset pulse, not just after
    // the first edge.
    s_ready    = en && !rst && ((state_q == IDLE) || last_data);
    accept     = s_valid && s_ready;
    frame_done = en && last_data;
    sym_valid  = (state_q != IDLE);
    busy       = (state_q != IDLE);
    sym_start  = sym_valid && (sample_q == '0);
    sample_idx = sample_q;

    case (state_q)
`ifdef BPSK_CTRL_PREAMBLE_EN
      PREAMBLE: sym_bit = ~cnt_q[0];  // symbol 0 -> 1, symbol 1 -> 0, ...
`endif
      DATA:     sym_bit = shreg_q[DATA_WIDTH-1];
      default:  sym_bit = 1'b0;
    endcase

    if (en) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_d  = s_data;
            sample_d = '0;
            cnt_d    = '0;
`ifdef BPSK_CTRL_PREAMBLE_EN
            state_d  = PREAMBLE;
`else
            state_d  = DATA;
`endif
          end
        end
`ifdef BPSK_CTRL_PREAMBLE_EN
        PREAMBLE: begin
          sample_d = sample_q + SW'(1);
          if (last_sample) begin
            if (cnt_q == CW'(PREAMBLE_LEN - 1)) begin
              cnt_d   = '0;
              state_d = DATA;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
`endif
        DATA: begin
          sample_d = sample_q + SW'(1);
          if (last_sample) begin
            shreg_d = shreg_q << 1;
            if (last_data) begin
              cnt_d = '0;
              // A chained word starts its data immediately: no preamble.
              if (accept) begin
                shreg_d = s_data;
              end else begin
                shreg_d = '0;
                state_d = IDLE;
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_symbol_ctrl.sv
module tb_bpsk_symbol_ctrl;
  localparam int SN = 256;
  localparam int DW = 12;
`ifdef BPSK_CTRL_PREAMBLE_EN
  localparam int NPRE = 8;
`else
  localparam int NPRE = 0;
`endif
  localparam int NSYM = NPRE + DW;
  localparam int DONE = NSYM * SN;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    sample_idx;
  logic          sym_bit, sym_valid, sym_start, frame_done, busy;

  bpsk_symbol_ctrl #(.SAMPLE_NUMBER(SN), .DATA_WIDTH(DW), .PREAMBLE_LEN(8)) dut (
    .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .sample_idx(sample_idx), .sym_bit(sym_bit),
    .sym_valid(sym_valid), .sym_start(sym_start), .frame_done(frame_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected sym_bit per symbol, first symbol in bit NSYM-1.
  typedef struct {
    logic [DW-1:0] word;
    logic [19:0]   bits;
  } vec_t;
  vec_t vt[4];

  // Accepts v.word on the next edge, then runs the frame to the end.
  task automatic run_frame(input vec_t v, input string nm);
    int fd_cnt;
    int fd_at;
    int busy_bad;
    s_data  = v.word;
    s_valid = 1'b1;
    chk({nm, " s_ready idle"}, s_ready, 1);
    step();
    s_valid = 1'b0;
    s_data  = ~v.word;  // must not disturb the captured word
    chk({nm, " first sym_start"}, {sym_valid, sym_start, sample_idx}, {1'b1, 1'b1, 8'd0});
    fd_cnt = 0; fd_at = -1; busy_bad = 0;
    for (int c = 1; c <= DONE; c++) begin
      if ((c - 1) % SN == SN / 2)
        chk($sformatf("%s sym_bit[%0d]", nm, (c - 1) / SN), sym_bit, v.bits[NSYM - 1 - (c - 1) / SN]);
      if (frame_done) begin fd_cnt++; fd_at = c; end
      if (!busy) busy_bad++;
      if (c < DONE) step();
    end
    chk({nm, " frame_done cycle"}, fd_at, DONE);
    chk({nm, " frame_done count"}, fd_cnt, 1);
    chk({nm, " busy during frame"}, busy_bad, 0);
    step();
    chk({nm, " idle after"}, {busy, sym_valid, sym_bit, sample_idx}, 11'd0);
  endtask

  initial begin
`ifdef BPSK_CTRL_PREAMBLE_EN
    vt[0] = '{12'hA5C, 20'hAAA5C};
    vt[1] = '{12'h3C1, 20'hAA3C1};
    vt[2] = '{12'h800, 20'hAA800};
    vt[3] = '{12'h5A3, 20'hAA5A3};
`else
    vt[0] = '{12'hA5C, 20'h00A5C};
    vt[1] = '{12'h3C1, 20'h003C1};
    vt[2] = '{12'h800, 20'h00800};
    vt[3] = '{12'h5A3, 20'h005A3};
`endif

    // Reset state, with an offered word that must be ignored.
    s_valid = 1'b1;
    s_data  = 12'hFFF;
    #1;
    chk("reset outputs", {s_ready, sym_bit, sym_valid, sym_start, frame_done, busy, sample_idx}, 14'd0);
    @(negedge clk);
    @(negedge clk);
    chk("reset held", {s_ready, busy, sample_idx}, 10'd0);

    // s_valid with en=0 in IDLE: nothing accepted.
    en = 1'b0;
    rst = 1'b0;
    begin
      int bad = 0;
      for (int i = 0; i < 5; i++) begin
        step();
        if (s_ready || busy || sym_valid) bad++;
      end
      chk("en=0 idle no accept", bad, 0);
    end
    s_valid = 1'b0;
    en = 1'b1;
    step();

    // Table-driven frames.
    for (int i = 0; i < 3; i++) run_frame(vt[i], $sformatf("vec%0d", i));

    // Back-to-back: 0xFFF then 0x000 held valid through the frame.
    begin
      int ss_bad = 0;
      int fd_at = -1;
      s_data = 12'hFFF; s_valid = 1'b1;
      step();
      s_data = 12'h000;  // held valid for the whole first frame
      for (int c = 1; c <= DONE; c++) begin
        if (sym_start != ((c - 1) % SN == 0)) ss_bad++;
        if (c < DONE) step();
      end
      chk("b2b s_ready last sample", {s_ready, frame_done}, 2'b11);
      step();
      s_valid = 1'b0;
      chk("b2b chained start", {busy, sym_start, sample_idx, sym_bit}, {1'b1, 1'b1, 8'd0, 1'b0});
      for (int c = 1; c <= DW * SN; c++) begin
        if (sym_start != ((c - 1) % SN == 0)) ss_bad++;
        if (c == SN / 2) chk("b2b second sym_bit", sym_bit, 0);
        if (frame_done && fd_at < 0) fd_at = c;
        if (c < DW * SN) step();
      end
      chk("b2b sym_start periodic", ss_bad, 0);
      chk("b2b second frame_done", fd_at, DW * SN);
      step();
      chk("b2b idle", busy, 0);
    end

    // Freeze for 100 cycles at sample 37 of data bit 3 of 0xA5C (bit = 0).
    begin
      int tgt = (NPRE + 3) * SN + 38;
      int c = 1;
      int bad = 0;
      int fd_at = -1;
      s_data = 12'hA5C; s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      while (c < tgt) begin step(); c++; end
      chk("freeze entry idx", sample_idx, 37);
      en = 1'b0;
      for (int i = 0; i < 100; i++) begin
        step(); c++;
        if (sample_idx != 8'd37 || sym_bit || !sym_valid || !busy || s_ready || frame_done || sym_start) bad++;
      end
      chk("freeze outputs held", bad, 0);
      en = 1'b1;
      step(); c++;
      chk("freeze resume idx", sample_idx, 38);
      while (fd_at < 0 && c <= DONE + 200) begin
        if (frame_done) fd_at = c;
        else begin step(); c++; end
      end
      chk("freeze frame_done delay", fd_at, DONE + 100);
      step();
    end

    // Asynchronous reset at sample 200 of symbol 5, then a fresh frame.
    begin
      int tgt = 5 * SN + 201;
      int c = 1;
      s_data = 12'h3C1; s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      while (c < tgt) begin step(); c++; end
      chk("pre-reset idx", sample_idx, 200);
      s_valid = 1'b1;
      rst = 1'b1;
      #1;
      chk("async reset outputs", {s_ready, sym_bit, sym_valid, sym_start, frame_done, busy, sample_idx}, 14'd0);
      #1;
      rst = 1'b0;
      s_valid = 1'b0;
      #1;
      run_frame(vt[3], "post-reset");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no summary expected finish");
    $fatal(1);
  end
endmodule
